// File: rtl/noc_credit_rx_port_if.sv
// Credit-link receive port signals: upstream flit/credit pair, downstream valid/ready, status.
// The slave modport is the receiving port itself; master is whoever drives and observes it.
interface noc_credit_rx_port_if #(
    parameter int FLIT_W = 20,
    parameter int PTR_W  = 2
);
    logic [FLIT_W-1:0] datain;
    logic              in_valid;
    logic              co;
    logic [FLIT_W-1:0] dataout;
    logic              out_valid;
    logic              out_ready;
    logic [PTR_W:0]    occupancy;
    logic              ovf;
    logic              proto_err;

    modport slave (
        input  datain, in_valid, out_ready,
        output co, dataout, out_valid, occupancy, ovf, proto_err
    );

    modport master (
        output datain, in_valid, out_ready,
        input  co, dataout, out_valid, occupancy, ovf, proto_err
    );
endinterface

// File: rtl/noc_credit_rx_port.sv
// Credit-based flit receive port: FWFT FIFO, one credit pulse per drained flit, overflow flag.
// Define PKT_CHECK_EN to add the packet-framing checker that drives proto_err.
//
// state  | meaning
// IDLE   | between packets; expects HEAD or SINGLE
// IN_PKT | inside a packet; expects BODY or TAIL
module noc_credit_rx_port #(
    parameter int FLIT_W = 20,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic                 clk,
    input  logic                 RST,
    noc_credit_rx_port_if.slave  link
);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    count;
    logic              co_q;
    logic              ovf_q;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = !empty && link.out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push  = link.in_valid && (!full || pop);
    assign drop  = link.in_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            co_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)
                count <= count + CNT_ONE;
            else if (pop && !push)
                count <= count - CNT_ONE;
            co_q <= pop;
            if (drop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= link.datain;
    end

    assign link.dataout   = empty ? '0 : mem[rd_ptr];
    assign link.out_valid = !empty;
    assign link.occupancy = count;
    assign link.co        = co_q;
    assign link.ovf       = ovf_q;

`ifdef PKT_CHECK_EN
    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    pkt_state_t state_q;
    pkt_state_t state_d;
    logic       err_d;
    logic       err_q;
    logic [1:0] ftype;

    assign ftype = link.datain[FLIT_W-1:FLIT_W-2];

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (err_d) err_q <= 1'b1;
        end
    end

    // Only flits that actually enter the FIFO advance the framing check.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (push) begin
            case (state_q)
                IDLE: begin
                    case (ftype)
                        T_HEAD:   state_d = IN_PKT;
                        T_SINGLE: state_d = IDLE;
                        default:  err_d   = 1'b1;
                    endcase
                end
                IN_PKT: begin
                    case (ftype)
                        T_BODY: state_d = IN_PKT;
                        T_TAIL: state_d = IDLE;
                        T_HEAD: begin
                            err_d   = 1'b1;
                            state_d = IN_PKT;
                        end
                        default: begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign link.proto_err = err_q;
`else
    assign link.proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_noc_credit_rx_port.sv
// Bench for noc_credit_rx_port: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_noc_credit_rx_port;
    localparam int FLIT_W = 20;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_credit_rx_port_if #(.FLIT_W(FLIT_W), .PTR_W(PTR_W)) link ();

    noc_credit_rx_port #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk  (clk),
        .RST  (rst),
        .link (link)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the FIFO is a plain queue, flags are booleans.
    logic [FLIT_W-1:0] m_q[$];
    bit m_co, m_ovf, m_err, m_in_pkt;

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_co = 0; m_ovf = 0; m_err = 0; m_in_pkt = 0;
        end else begin
            bit did_pop, was_full;
            did_pop  = (m_q.size() > 0) && link.out_ready;
            was_full = (m_q.size() == DEPTH);
            m_co = did_pop;
            if (did_pop) void'(m_q.pop_front());
            if (link.in_valid) begin
                if (!was_full || did_pop) begin
                    m_q.push_back(link.datain);
`ifdef PKT_CHECK_EN
                    case (link.datain[FLIT_W-1:FLIT_W-2])
                        2'b10: begin if (m_in_pkt) m_err = 1; m_in_pkt = 1; end
                        2'b11: begin if (m_in_pkt) m_err = 1; m_in_pkt = 0; end
                        2'b00: begin if (!m_in_pkt) m_err = 1; end
                        default: begin if (!m_in_pkt) m_err = 1; m_in_pkt = 0; end
                    endcase
`endif
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare against the model, plus observation logs for directed checks.
    bit check_en = 0;
    int co_cnt = 0;
    int max_occ = 0;
    logic [FLIT_W-1:0] out_log[$];

    always @(negedge clk) begin
        if (check_en) begin
            chk("out_valid", {31'd0, link.out_valid}, {31'd0, m_q.size() != 0});
            chk("dataout", {12'd0, link.dataout}, (m_q.size() != 0) ? {12'd0, m_q[0]} : 32'd0);
            chk("occupancy", {29'd0, link.occupancy}, m_q.size());
            chk("co", {31'd0, link.co}, {31'd0, m_co});
            chk("ovf", {31'd0, link.ovf}, {31'd0, m_ovf});
            chk("proto_err", {31'd0, link.proto_err}, {31'd0, m_err});
            if (link.co) co_cnt++;
            if (int'(link.occupancy) > max_occ) max_occ = int'(link.occupancy);
            if (link.out_valid && link.out_ready) out_log.push_back(link.dataout);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input logic [FLIT_W-1:0] d);
        link.datain   = d;
        link.in_valid = 1'b1;
        cyc(1);
        link.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
    endtask

    initial begin
        logic [FLIT_W-1:0] exp_pkt[4];
        link.datain    = '0;
        link.in_valid  = 1'b0;
        link.out_ready = 1'b0;
        cyc(2);
        check_en = 1;
        rst = 1'b0;

        // Reset and idle
        cyc(5);
        chk("rst_out_valid", {31'd0, link.out_valid}, 32'd0);
        chk("rst_occ", {29'd0, link.occupancy}, 32'd0);
        chk("rst_co_cnt", co_cnt, 0);
        chk("rst_ovf", {31'd0, link.ovf}, 32'd0);
        chk("rst_perr", {31'd0, link.proto_err}, 32'd0);

        // Fill with no drain, then drain in order
        for (int i = 1; i <= 4; i++) push1(20'h80000 + 20'(i));
        chk("fill_occ", {29'd0, link.occupancy}, 32'd4);
        chk("fill_head", {12'd0, link.dataout}, 32'h80001);
        chk("fill_no_co", co_cnt, 0);
        out_log.delete();
        link.out_ready = 1'b1;
        cyc(4);
        link.out_ready = 1'b0;
        cyc(1);
        chk("drain_cnt", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            chk("drain_order", {12'd0, out_log[i]}, 32'h80001 + i);
        chk("drain_co", co_cnt, 4);
        chk("drain_occ", {29'd0, link.occupancy}, 32'd0);

        // Overflow: contents preserved, flag sticky
        for (int i = 1; i <= 4; i++) push1(20'h00010 + 20'(i));
        push1(20'h00AAA);
        chk("ovf_set", {31'd0, link.ovf}, 32'd1);
        chk("ovf_occ", {29'd0, link.occupancy}, 32'd4);
        out_log.delete();
        link.out_ready = 1'b1;
        cyc(5);
        link.out_ready = 1'b0;
        chk("ovf_rd_cnt", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            chk("ovf_rd", {12'd0, out_log[i]}, 32'h00011 + i);
        chk("ovf_sticky", {31'd0, link.ovf}, 32'd1);

        // Full with same-cycle push and pop
        do_reset();
        chk("rst_ovf_clr", {31'd0, link.ovf}, 32'd0);
        for (int i = 1; i <= 4; i++) push1(20'h00020 + 20'(i));
        out_log.delete();
        co_cnt = 0;
        link.out_ready = 1'b1;
        push1(20'h40555);
        chk("pp_co", {31'd0, link.co}, 32'd1);
        chk("pp_occ", {29'd0, link.occupancy}, 32'd4);
        chk("pp_no_ovf", {31'd0, link.ovf}, 32'd0);
        cyc(5);
        link.out_ready = 1'b0;
        chk("pp_rd_cnt", out_log.size(), 5);
        if (out_log.size() == 5) chk("pp_last", {12'd0, out_log[4]}, 32'h40555);
        chk("pp_co_cnt", co_cnt, 5);

        // Continuous stream through wrapping pointers
        do_reset();
        out_log.delete();
        co_cnt = 0;
        max_occ = 0;
        link.out_ready = 1'b1;
        link.in_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            link.datain = 20'h00100 + 20'(i);
            cyc(1);
            chk("stream_occ1", {29'd0, link.occupancy}, 32'd1);
        end
        link.in_valid = 1'b0;
        cyc(1);
        chk("stream_occ0", {29'd0, link.occupancy}, 32'd0);
        link.out_ready = 1'b0;
        cyc(1);
        chk("stream_cnt", out_log.size(), 20);
        for (int i = 0; i < 20 && i < out_log.size(); i++)
            chk("stream_order", {12'd0, out_log[i]}, 32'h00100 + i);
        chk("stream_co", co_cnt, 20);
        chk("stream_max_occ", max_occ, 1);

        // Framing: HEAD, BODY, HEAD (error), TAIL
        do_reset();
        out_log.delete();
        link.out_ready = 1'b1;
        exp_pkt[0] = 20'h80000; exp_pkt[1] = 20'h00001;
        exp_pkt[2] = 20'h80002; exp_pkt[3] = 20'h40003;
        push1(exp_pkt[0]);
        push1(exp_pkt[1]);
        chk("pkt_ok_so_far", {31'd0, link.proto_err}, 32'd0);
        push1(exp_pkt[2]);
`ifdef PKT_CHECK_EN
        chk("pkt_err_set", {31'd0, link.proto_err}, 32'd1);
`else
        chk("pkt_err_off", {31'd0, link.proto_err}, 32'd0);
`endif
        push1(exp_pkt[3]);
        cyc(3);
`ifdef PKT_CHECK_EN
        chk("pkt_err_sticky", {31'd0, link.proto_err}, 32'd1);
`else
        chk("pkt_err_off2", {31'd0, link.proto_err}, 32'd0);
`endif
        chk("pkt_cnt", out_log.size(), 4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            chk("pkt_data", {12'd0, out_log[i]}, {12'd0, exp_pkt[i]});
        link.out_ready = 1'b0;
        do_reset();
        chk("pkt_err_clr", {31'd0, link.proto_err}, 32'd0);

        cyc(2);
        check_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
